// File: rtl/div_recompose_pkg.sv
// div_recompose_pkg: shared types and sizing for the numer recomposition block.
// State encoding, default operand widths and the iteration counter sizing.
package div_recompose_pkg;

  localparam int QW_DEF = 10;
  localparam int DW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index DW iterations; never let it collapse to zero bits.
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DW_DEF);

endpackage

// File: rtl/div_recompose_dp.sv
// div_recompose_dp: shift-add datapath computing quotient*denom + remain.
// load seeds the registers from the operands; each step consumes one denom bit.
module div_recompose_dp
  import div_recompose_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             load,
  input  logic             step,
  input  logic [QW-1:0]    quotient,
  input  logic [DW-1:0]    denom,
  input  logic [DW-1:0]    remain,
  output logic [QW+DW-1:0] acc
);

  logic [QW+DW-1:0] mcand;
  logic [DW-1:0]    mplier;

  // Accumulator, shifted multiplicand and multiplier bit stream.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= {{QW{1'b0}}, remain};
      mcand  <= {{DW{1'b0}}, quotient};
      mplier <= denom;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end else begin
        acc <= acc;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else begin
      acc    <= acc;
      mcand  <= mcand;
      mplier <= mplier;
    end
  end

endmodule

// File: rtl/div_recompose.sv
// div_recompose: rebuilds numer = quotient*denom + remain over DW clock cycles.
// FSM and valid/ready handshakes live here; arithmetic is in div_recompose_dp.
// Optional macro DIV_RECOMPOSE_CHECK_EN builds the operand range check driving err;
// without it err is tied low.
module div_recompose
  import div_recompose_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    quotient,
  input  logic [DW-1:0]    denom,
  input  logic [DW-1:0]    remain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW+DW-1:0] numer,
  output logic             err
);

  localparam int CW = cnt_width(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             err_chk;
  logic [QW+DW-1:0] acc;

  assign load = (state == IDLE) && in_valid;
  assign step = (state == RUN);

  // State register.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: fixed DW iterations, then hold until drained.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) next_state = RUN;
        else          next_state = IDLE;
      end
      RUN: begin
        if (cnt == LAST) next_state = DONE;
        else             next_state = RUN;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
        else           next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Iteration counter, restarted on every accepted operand set.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

`ifdef DIV_RECOMPOSE_CHECK_EN
  logic err_flag;

  // Range flag captured with the operands, dropped once the result is taken.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      err_flag <= 1'b0;
    end else if (load) begin
      err_flag <= (denom == '0) || (remain >= denom);
    end else if ((state == DONE) && out_ready) begin
      err_flag <= 1'b0;
    end else begin
      err_flag <= err_flag;
    end
  end

  assign err_chk = err_flag;
`else
  assign err_chk = 1'b0;
`endif

  div_recompose_dp #(
    .QW(QW),
    .DW(DW)
  ) u_dp (
    .clock    (clock),
    .aclr     (aclr),
    .load     (load),
    .step     (step),
    .quotient (quotient),
    .denom    (denom),
    .remain   (remain),
    .acc      (acc)
  );

  // Outputs decoded from registered state only; numer/err are zero outside DONE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    numer     = '0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        in_ready = 1'b0;
      end
      DONE: begin
        out_valid = 1'b1;
        numer     = acc;
        err       = err_chk;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_recompose.sv
// tb_div_recompose: directed checks of div_recompose with hand-computed results.
module tb_div_recompose;

  logic        clock = 1'b0;
  logic        aclr;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  quotient;
  logic [3:0]  denom;
  logic [3:0]  remain;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] numer;
  logic        err;

  int total = 0;
  int bad   = 0;

`ifdef DIV_RECOMPOSE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  always #5 clock = ~clock;

  div_recompose dut (
    .clock     (clock),
    .aclr      (aclr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .denom     (denom),
    .remain    (remain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .numer     (numer),
    .err       (err)
  );

  // Present operands, take them on one edge, then scramble the inputs.
  task automatic start_op(input logic [9:0] q, input logic [3:0] d, input logic [3:0] r);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL accept_ready got=%b want=1", in_ready);
    end
    quotient = q; denom = d; remain = r; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    quotient = 10'h2AA; denom = 4'h9; remain = 4'h7;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [9:0] q, input logic [3:0] d,
                           input logic [3:0] r, input logic [13:0] want_n, input logic want_e);
    int lat;
    start_op(q, d, r);
    wait_done(lat);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL %s_valid got=%b want=1", name, out_valid);
    end
    total++;
    if (numer !== want_n) begin
      bad++; $display("FAIL %s_numer got=%0d want=%0d", name, numer, want_n);
    end
    total++;
    if (err !== want_e) begin
      bad++; $display("FAIL %s_err got=%b want=%b", name, err, want_e);
    end
    drain();
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (numer !== 14'd0) begin bad++; $display("FAIL reset_numer got=%0d want=0", numer); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_basic();
    int lat;
    start_op(10'd37, 4'd5, 4'd3);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", in_ready); end
    wait_done(lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
    total++;
    if (numer !== 14'd188) begin bad++; $display("FAIL basic_numer got=%0d want=188", numer); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", err); end
    drain();
  endtask

  task automatic test_corners();
    run_check("max",     10'd1023, 4'd15, 4'd14, 14'd15359, 1'b0);
    run_check("zero_d",  10'd500,  4'd0,  4'd0,  14'd0,     CHK);
    run_check("big_rem", 10'd10,   4'd5,  4'd6,  14'd56,    CHK);
    run_check("d_one",   10'd777,  4'd1,  4'd0,  14'd777,   1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(10'd10, 4'd5, 4'd6);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      total++;
      if (out_valid !== 1'b1 || numer !== 14'd56 || err !== CHK) begin
        bad++; $display("FAIL hold_%0d got=v%b n%0d e%b want=v1 n56 e%b", i, out_valid, numer, err, CHK);
      end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL post_hs got=v%b r%b e%b want=v0 r1 e0", out_valid, in_ready, err);
    end
    quotient = 10'd4; denom = 4'd4; remain = 4'd1; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL resume_accept got=%b want=0", in_ready); end
    wait_done(lat);
    total++;
    if (numer !== 14'd17 || lat !== 4) begin
      bad++; $display("FAIL resume_result got=n%0d l%0d want=n17 l4", numer, lat);
    end
    drain();
  endtask

  task automatic test_abort();
    start_op(10'd300, 4'd7, 4'd2);
    @(posedge clock); #1;
    aclr = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL abort got=v%b r%b want=v0 r1", out_valid, in_ready);
    end
    @(posedge clock); #1;
    aclr = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=v%b r%b want=v0 r1", out_valid, in_ready);
    end
    run_check("after_abort", 10'd2, 4'd3, 4'd1, 14'd7, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_check("b2b_a", 10'd100, 4'd9, 4'd8, 14'd908, 1'b0);
    run_check("b2b_b", 10'd63,  4'd10, 4'd11, 14'd641, CHK);
  endtask

  initial begin
    aclr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    quotient = '0; denom = '0; remain = '0;
    #12;
    test_reset();
    @(posedge clock); #1;
    aclr = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
